// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA line-fetch slice: system state
// codes, coordinate/pixel widths and the fetch FSM encoding.
package vga_pkg;

  localparam logic [7:0] SYS_DISPLAY = 8'h03;
  localparam int         COORD_W     = 12;
  localparam int         PIX_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/line_buf_dp.sv
// Simple dual-port line buffer: one write port, one registered read port.
module line_buf_dp #(
  parameter int DEPTH = 400,
  parameter int ABITS = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [15:0]      wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [15:0]      rdata
);

  logic [15:0] mem [DEPTH];

  // NOTE: memory arrays carry no reset so they map onto block RAM; only
  // control state is reset, and readers never rely on initial contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_line_fetch.sv
// Fetches one image row from SPRAM into the back half of a ping-pong line
// buffer while the front half is scanned out as RGB565 pixels.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int W        = 200,
  parameter int H        = 150,
  parameter int STARTROW = 0,
  parameter int STARTCOL = 0,
  parameter int AW       = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         state,
  input  logic               rd_sig,
  input  logic [COORD_W-1:0] xpos,
  input  logic [COORD_W-1:0] ypos,
  output logic [AW-1:0]      spram_addr,
  output logic               spram_rden,
  input  logic [PIX_W-1:0]   spram_rdata,
  output logic [4:0]         vga_r,
  output logic [5:0]         vga_g,
  output logic [4:0]         vga_b,
  output logic               fetch_ovf
);

  localparam int BW = $clog2(2 * W);
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  localparam logic [COORD_W:0] X_LO = (COORD_W + 1)'(STARTCOL);
  localparam logic [COORD_W:0] X_HI = (COORD_W + 1)'(STARTCOL + W);
  localparam logic [COORD_W:0] Y_LO = (COORD_W + 1)'(STARTROW);
  localparam logic [COORD_W:0] Y_HI = (COORD_W + 1)'(STARTROW + H);

  fetch_state_t fsm_q, fsm_d;
  logic [IW-1:0] idx_q, idx_d, wr_idx_q;
  logic [RW-1:0] row_q;
  logic [AW-1:0] row_base_q, addr_d;
  logic          rden_d, front_q, wr_en_q, pix_valid_q, display, in_win;
  logic [BW-1:0] wr_addr, rd_addr, x_off;
  logic [PIX_W-1:0] buf_rdata;

  assign display = (state == SYS_DISPLAY);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) fsm_q <= ST_IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next-state logic; leaving the display state aborts any fetch.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fsm_d = fsm_q;
    if (!display) begin
      fsm_d = ST_IDLE;
    end else begin
      case (fsm_q)
        ST_IDLE:  if (rd_sig) fsm_d = ST_FETCH;
        ST_FETCH: if (idx_q == IW'(W - 1)) fsm_d = ST_DRAIN;
        ST_DRAIN: fsm_d = ST_IDLE;
        default:  fsm_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered SPRAM read interface.
  always_comb begin
    rden_d = 1'b0;
    idx_d  = idx_q;
    addr_d = spram_addr;
    if (fsm_d == ST_FETCH) begin
      idx_d  = (fsm_q == ST_IDLE) ? '0 : idx_q + 1'b1;
      rden_d = 1'b1;
      addr_d = row_base_q + AW'(idx_d);
    end
  end

  // Datapath registers. Read data arrives one cycle after rden, so the write
  // strobe and index trail the read by one cycle; the last write and the
  // bank swap share the DRAIN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      wr_idx_q    <= '0;
      wr_en_q     <= 1'b0;
      row_q       <= '0;
      row_base_q  <= '0;
      front_q     <= 1'b0;
      spram_rden  <= 1'b0;
      spram_addr  <= '0;
      fetch_ovf   <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      wr_idx_q    <= idx_q;
      wr_en_q     <= spram_rden && display;
      spram_rden  <= rden_d;
      spram_addr  <= addr_d;
      pix_valid_q <= display && in_win;
      if (rd_sig && fsm_q != ST_IDLE) fetch_ovf <= 1'b1;
      if (!display) begin
        row_q      <= '0;
        row_base_q <= '0;
      end else if (fsm_q == ST_DRAIN) begin
        front_q <= ~front_q;
        if (row_q == RW'(H - 1)) begin
          row_q      <= '0;
          row_base_q <= '0;
        end else begin
          row_q      <= row_q + 1'b1;
          row_base_q <= row_base_q + AW'(W);
        end
      end
    end
  end

  // Bank 0 occupies entries 0..W-1 and bank 1 entries W..2W-1.
  assign in_win  = ({1'b0, xpos} >= X_LO) && ({1'b0, xpos} < X_HI) &&
                   ({1'b0, ypos} >= Y_LO) && ({1'b0, ypos} < Y_HI);
  assign x_off   = BW'(xpos - COORD_W'(STARTCOL));
  assign rd_addr = !in_win ? '0 : (front_q ? BW'(W) + x_off : x_off);
  assign wr_addr = front_q ? BW'(wr_idx_q) : BW'(W) + BW'(wr_idx_q);

  line_buf_dp #(.DEPTH(2 * W), .ABITS(BW)) u_buf (
    .clk   (clk),
    .we    (wr_en_q),
    .waddr (wr_addr),
    .wdata (spram_rdata),
    .raddr (rd_addr),
    .rdata (buf_rdata)
  );

  assign {vga_r, vga_g, vga_b} = pix_valid_q ? buf_rdata : '0;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch with W=4, H=3 and an offset window;
// the SPRAM model returns addr + 16'h100 one cycle after each read.
module tb_vga_line_fetch;

  localparam int W = 4, H = 3, SR = 2, SC = 5, AW = 15;

  logic          clk = 1'b0;
  logic          rst, rd_sig;
  logic [7:0]    state;
  logic [11:0]   xpos, ypos;
  logic [AW-1:0] spram_addr;
  logic          spram_rden, fetch_ovf;
  logic [15:0]   spram_rdata;
  logic [4:0]    vga_r, vga_b;
  logic [5:0]    vga_g;
  logic [15:0]   rgb;
  int            n_vec = 0, n_err = 0;

  vga_line_fetch #(.W(W), .H(H), .STARTROW(SR), .STARTCOL(SC), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .state       (state),
    .rd_sig      (rd_sig),
    .xpos        (xpos),
    .ypos        (ypos),
    .spram_addr  (spram_addr),
    .spram_rden  (spram_rden),
    .spram_rdata (spram_rdata),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .fetch_ovf   (fetch_ovf)
  );

  always #5 clk = ~clk;
  assign rgb = {vga_r, vga_g, vga_b};

  always @(posedge clk) begin
    if (spram_rden) spram_rdata <= 16'(spram_addr) + 16'h0100;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One row fetch: rden must stay high exactly W cycles on base..base+W-1,
  // drop in DRAIN, and the displayed pixel flips one cycle after the swap.
  task automatic do_fetch(input logic [AW-1:0] base, input bit inject_ovf,
                          input bit chk_old, input logic [15:0] old_pix,
                          input bit chk_new, input logic [15:0] new_pix);
    rd_sig = 1'b1;
    tick();
    rd_sig = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("fetch_rden", 32'(spram_rden), 32'd1);
      check("fetch_addr", 32'(spram_addr), 32'(base) + 32'(i));
      if (inject_ovf && i == 1) rd_sig = 1'b1;
      tick();
      rd_sig = 1'b0;
    end
    check("drain_rden", 32'(spram_rden), 32'd0);
    tick();
    check("swap_rden", 32'(spram_rden), 32'd0);
    if (chk_old) check("pix_before_swap", 32'(rgb), 32'(old_pix));
    tick();
    if (chk_new) check("pix_after_swap", 32'(rgb), 32'(new_pix));
  endtask

  task automatic pix(input string tag, input logic [11:0] x, input logic [11:0] y,
                     input logic [15:0] exp);
    xpos = x;
    ypos = y;
    tick();
    check(tag, 32'(rgb), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    rd_sig = 1'b0;
    state  = 8'h03;
    xpos   = 12'(SC + 2);
    ypos   = 12'(SR);
    tick();
    tick();
    check("rst_rden", 32'(spram_rden), 32'd0);
    check("rst_addr", 32'(spram_addr), 32'd0);
    check("rst_rgb",  32'(rgb),        32'd0);
    check("rst_ovf",  32'(fetch_ovf),  32'd0);
    rst = 1'b0;
    tick();

    // Row 0 into the buffer, then window interior and edges.
    do_fetch(15'd0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0102);
    pix("pix_c2_r0",   12'(SC + 2),     12'(SR),     16'h0102);
    pix("pix_c0_r0",   12'(SC),         12'(SR),     16'h0100);
    pix("pix_clast",   12'(SC + W - 1), 12'(SR + H - 1), 16'h0103);
    pix("edge_x_hi",   12'(SC + W),     12'(SR),     16'h0000);
    pix("edge_x_lo",   12'(SC - 1),     12'(SR),     16'h0000);
    pix("edge_y_fff",  12'(SC + 2),     12'hFFF,     16'h0000);
    pix("edge_y_hi",   12'(SC + 2),     12'(SR + H), 16'h0000);
    pix("edge_y_lo",   12'(SC + 2),     12'(SR - 1), 16'h0000);
    pix("pix_back_in", 12'(SC + 2),     12'(SR),     16'h0102);

    // Row 1 with an overrun request mid-fetch; no extra row may follow.
    check("ovf_clear", 32'(fetch_ovf), 32'd0);
    do_fetch(15'd4, 1'b1, 1'b1, 16'h0102, 1'b1, 16'h0106);
    check("ovf_set", 32'(fetch_ovf), 32'd1);
    tick();
    check("no_extra_rden", 32'(spram_rden), 32'd0);
    tick();
    check("no_extra_rden2", 32'(spram_rden), 32'd0);

    // Row 2, then the fourth fetch wraps back to row 0.
    do_fetch(15'd8, 1'b0, 1'b1, 16'h0106, 1'b1, 16'h010A);
    do_fetch(15'd0, 1'b0, 1'b1, 16'h010A, 1'b1, 16'h0102);
    check("ovf_sticky", 32'(fetch_ovf), 32'd1);

    // Abort mid-fetch of row 1 by leaving the display state.
    rd_sig = 1'b1;
    tick();
    rd_sig = 1'b0;
    check("abort_addr0", 32'(spram_addr), 32'd4);
    tick();
    check("abort_addr1", 32'(spram_addr), 32'd5);
    state = 8'h02;
    tick();
    check("abort_rden", 32'(spram_rden), 32'd0);
    check("abort_rgb",  32'(rgb),        32'd0);
    tick();
    check("abort_idle", 32'(spram_rden), 32'd0);
    state = 8'h03;
    tick();
    do_fetch(15'd0, 1'b0, 1'b1, 16'h0102, 1'b1, 16'h0102);

    // Reset mid-fetch of row 1.
    rd_sig = 1'b1;
    tick();
    rd_sig = 1'b0;
    check("rstmid_addr0", 32'(spram_addr), 32'd4);
    tick();
    rst = 1'b1;
    tick();
    check("rstmid_rden", 32'(spram_rden), 32'd0);
    check("rstmid_addr", 32'(spram_addr), 32'd0);
    check("rstmid_rgb",  32'(rgb),        32'd0);
    check("rstmid_ovf",  32'(fetch_ovf),  32'd0);
    rst = 1'b0;
    tick();
    do_fetch(15'd0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0102);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch.md
VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 SHALL have parameter W, default 200, meaning image width in pixels.
REQ-002 SHALL have parameter H, default 150, meaning image height in rows.
REQ-003 SHALL have parameter STARTROW, default 0, meaning first display row of the image.
REQ-004 SHALL have parameter STARTCOL, default 0, meaning first display column of the image.
REQ-005 SHALL have parameter AW, default 15, meaning SPRAM address width.
REQ-006 SHALL have port clk, input, 1 bit: pixel clock; the block's only clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port state, input, 8 bits: system state (8'h03 = display).
REQ-009 SHALL have port rd_sig, input, 1 bit: one-cycle row-fetch request from the timing generator.
REQ-010 SHALL have ports xpos and ypos, input, 12 bits each: display-relative pixel coordinates, unsigned.
REQ-011 SHALL have port spram_addr, output, AW bits: SPRAM read address.
REQ-012 SHALL have port spram_rden, output, 1 bit: SPRAM read enable.
REQ-013 SHALL have port spram_rdata, input, 16 bits: RGB565 data, valid 1 cycle after spram_rden.
REQ-014 SHALL have ports vga_r (5 bits), vga_g (6 bits) and vga_b (5 bits), outputs: registered pixel colour.
REQ-015 SHALL have port fetch_ovf, output, 1 bit: sticky flag, set when a request arrives while busy.

Function
REQ-016 SHALL contain a ping-pong line buffer of 2×W 16-bit words: a front bank (displayed) and a back bank (filled).
REQ-017 FSM SHALL have states IDLE, FETCH and DRAIN.
- IDLE->FETCH: on rd_sig=1 with state==8'h03.
- FETCH->DRAIN: after W reads have been issued.
- DRAIN->IDLE: after the last read data has been written to the back bank; on this cycle the banks SHALL swap.
REQ-018 In FETCH, the block SHALL assert spram_rden for exactly W consecutive cycles, with spram_addr = row_idx*W + i for i = 0..W-1, truncated to AW bits.
REQ-019 Each spram_rdata word SHALL be written to back bank entry i one cycle after its read, so a row takes W+2 cycles from rd_sig to swap.
REQ-020 row_idx SHALL increment on each swap and wrap from H-1 to 0.
REQ-021 rd_sig received in FETCH or DRAIN SHALL be ignored and SHALL set fetch_ovf; fetch_ovf clears only on rst.
REQ-022 Pixel output:
- If STARTCOL <= xpos < STARTCOL+W and STARTROW <= ypos < STARTROW+H, the block SHALL register front[xpos-STARTCOL] onto vga_r/g/b, split as [15:11], [10:5], [4:0].
- Otherwise the outputs SHALL be 0.
- Latency SHALL be exactly 1 clk.
REQ-023 Out-of-display coordinates (12-bit wrapped values) SHALL fall outside the window and produce black.
REQ-024 When state != 8'h03, the block SHALL abort any fetch: FSM to IDLE, spram_rden=0, row_idx=0, RGB=0; buffer contents are don't-care.
REQ-025 spram_rden SHALL be 0 in IDLE and DRAIN.

Reset
REQ-026 On rst=1 at a clk edge, the block SHALL set FSM=IDLE, row_idx=0, front bank select=0, spram_rden=0, spram_addr=0, vga_r/g/b=0 and fetch_ovf=0; reset SHALL take priority over all inputs, including mid-fetch.

Structure
REQ-027 State encodings and the constant 8'h03 (display state) SHALL be defined in the shared package vga_pkg, alongside the timing constants.
REQ-028 The line buffer SHALL be one sub-module, line_buf_dp: a simple dual-port memory of 2W×16 with 1 write port and 1 registered read port.

Verification
REQ-029 Scenario, single fetch: W=4, state=3, pulse rd_sig, SPRAM model returns addr+16'h100 -> rden high 4 cycles with addr 0,1,2,3, bank swap at cycle 6 after rd_sig.
REQ-030 Scenario, display: after REQ-029's fetch, drive xpos=STARTCOL+2, ypos=STARTROW -> next cycle {r,g,b} = 16'h0102.
REQ-031 Scenario, row wrap: H=3, issue 4 fetches -> addresses of the 4th fetch restart at 0.
REQ-032 Scenario, overrun: rd_sig during FETCH -> fetch_ovf=1, the address sequence is unchanged, and no extra row is fetched.
REQ-033 Scenario, window edges: xpos=STARTCOL+W or ypos=12'hFFF -> RGB=0 next cycle.
REQ-034 Scenario, abort and reset: state goes to 8'h02 mid-fetch -> rden=0 next cycle and the next fetch uses row 0; the same scenario with rst=1 gives all outputs 0.
